// File: rtl/dcpu_defines.sv
// Shared constants and types for the DCPU-16 operand fetch/decode block.
package dcpu_defines;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CODE_W = 6;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;

  localparam logic [OP_W-1:0] OP_NONBASIC = 4'h0;

  localparam logic [CODE_W-1:0] VAL_POP    = 6'h18;
  localparam logic [CODE_W-1:0] VAL_PEEK   = 6'h19;
  localparam logic [CODE_W-1:0] VAL_PUSH   = 6'h1a;
  localparam logic [CODE_W-1:0] VAL_SP     = 6'h1b;
  localparam logic [CODE_W-1:0] VAL_PC     = 6'h1c;
  localparam logic [CODE_W-1:0] VAL_O      = 6'h1d;
  localparam logic [CODE_W-1:0] VAL_NW_IND = 6'h1e;
  localparam logic [CODE_W-1:0] VAL_NW_LIT = 6'h1f;

  typedef enum logic [3:0] {
    IDLE, FETCH, A_EVAL, A_WORD, A_READ, B_EVAL, B_WORD, B_READ, OUT
  } state_e;

  typedef enum logic [3:0] {
    K_REG, K_REG_IND, K_REG_NW_IND, K_POP, K_PEEK, K_PUSH,
    K_SP, K_PC, K_O, K_NW_IND, K_NW_LIT, K_LIT
  } kind_e;

endpackage

// File: rtl/dcpu_operand_class.sv
// Classifies a 6-bit DCPU-16 operand code into its addressing kind.
module dcpu_operand_class
  import dcpu_defines::*;
(
  input  logic [CODE_W-1:0] code_i,
  output kind_e             kind_o
);

  always_comb begin
    kind_o = K_LIT;
    if (!code_i[5]) begin
      unique case (code_i[4:3])
        2'd0: kind_o = K_REG;
        2'd1: kind_o = K_REG_IND;
        2'd2: kind_o = K_REG_NW_IND;
        default: begin
          unique case (code_i)
            VAL_POP:    kind_o = K_POP;
            VAL_PEEK:   kind_o = K_PEEK;
            VAL_PUSH:   kind_o = K_PUSH;
            VAL_SP:     kind_o = K_SP;
            VAL_PC:     kind_o = K_PC;
            VAL_O:      kind_o = K_O;
            VAL_NW_IND: kind_o = K_NW_IND;
            VAL_NW_LIT: kind_o = K_NW_LIT;
            default:    kind_o = K_LIT;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/dcpu_operand_fetch.sv
// DCPU-16 instruction fetch and operand evaluation: reads the instruction,
// resolves a then b (registers, stack, next-word, indirect) and holds results.
module dcpu_operand_fetch
  import dcpu_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] sp_in,
  input  logic [WORD_W-1:0] o_in,
  output logic [REG_W-1:0]  rf_raddr,
  input  logic [WORD_W-1:0] rf_rdata,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              valid,
  input  logic              ready,
  output logic [OP_W-1:0]   opcode,
  output logic [CODE_W-1:0] a_code,
  output logic [CODE_W-1:0] b_code,
  output logic [WORD_W-1:0] a_val,
  output logic [WORD_W-1:0] b_val,
  output logic [WORD_W-1:0] a_addr,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] sp_out,
  output logic              busy
);

  state_e state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d, sp_q, sp_d, o_q, o_d;
  logic [WORD_W-1:0] a_val_q, a_val_d, b_val_q, b_val_d, a_addr_q, a_addr_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [CODE_W-1:0] a_code_q, a_code_d, b_code_q, b_code_d;
  logic [REG_W-1:0]  rf_raddr_q, rf_raddr_d;
  logic              mem_req_q, mem_req_d, valid_q, valid_d, busy_q, busy_d;

  logic              is_b;
  logic [CODE_W-1:0] cur_code;
  kind_e             kind;
  state_e            next_op_state;
  logic              ev_direct, ev_word, op_done;
  logic [WORD_W-1:0] ev_val, ev_addr, ev_sp, word_addr, op_val;

  assign is_b          = (state_q == B_EVAL) || (state_q == B_WORD) || (state_q == B_READ);
  assign cur_code      = is_b ? b_code_q : a_code_q;
  assign next_op_state = (is_b || (opcode_q == OP_NONBASIC)) ? OUT : B_EVAL;
  assign word_addr     = mem_rdata + ((kind == K_REG_NW_IND) ? rf_rdata : '0);

  dcpu_operand_class u_class (
    .code_i (cur_code),
    .kind_o (kind)
  );

  // Single-cycle resolution of the current operand in X_EVAL.
  always_comb begin
    ev_direct = 1'b1;
    ev_word   = 1'b0;
    ev_val    = rf_rdata;
    ev_addr   = rf_rdata;
    ev_sp     = sp_q;
    case (kind)
      K_REG:     ev_direct = 1'b1;
      K_REG_IND: ev_direct = 1'b0;
      K_REG_NW_IND, K_NW_IND, K_NW_LIT: begin
        ev_direct = 1'b0;
        ev_word   = 1'b1;
      end
      K_POP: begin
        ev_direct = 1'b0;
        ev_addr   = sp_q;
        ev_sp     = sp_q + 16'd1;
      end
      K_PEEK: begin
        ev_direct = 1'b0;
        ev_addr   = sp_q;
      end
      K_PUSH: begin
        ev_direct = 1'b0;
        ev_addr   = sp_q - 16'd1;
        ev_sp     = sp_q - 16'd1;
      end
      K_SP:    ev_val = sp_q;
      K_PC:    ev_val = pc_q;
      K_O:     ev_val = o_q;
      K_LIT:   ev_val = WORD_W'(cur_code[4:0]);
      default: ev_direct = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    o_d        = o_q;
    opcode_d   = opcode_q;
    a_code_d   = a_code_q;
    b_code_d   = b_code_q;
    a_val_d    = a_val_q;
    b_val_d    = b_val_q;
    a_addr_d   = a_addr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rf_raddr_d = rf_raddr_q;
    op_done    = 1'b0;
    op_val     = ev_val;
    unique case (state_q)
      IDLE: if (start) begin
        pc_d       = pc_in;
        sp_d       = sp_in;
        o_d        = o_in;
        a_val_d    = '0;
        b_val_d    = '0;
        a_addr_d   = '0;
        mem_req_d  = 1'b1;
        mem_addr_d = pc_in;
        state_d    = FETCH;
      end
      FETCH: if (mem_ack) begin
        opcode_d = mem_rdata[3:0];
        if (mem_rdata[3:0] == OP_NONBASIC) begin
          a_code_d = mem_rdata[15:10];
          b_code_d = mem_rdata[9:4];
        end else begin
          a_code_d = mem_rdata[9:4];
          b_code_d = mem_rdata[15:10];
        end
        rf_raddr_d = a_code_d[2:0];
        pc_d       = pc_q + 16'd1;
        mem_req_d  = 1'b0;
        state_d    = A_EVAL;
      end
      A_EVAL, B_EVAL: begin
        sp_d = ev_sp;
        if (ev_direct) begin
          op_done = 1'b1;
        end else if (ev_word) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = is_b ? B_WORD : A_WORD;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = ev_addr;
          state_d    = is_b ? B_READ : A_READ;
          if (!is_b) a_addr_d = ev_addr;
        end
      end
      A_WORD, B_WORD: if (mem_ack) begin
        pc_d = pc_q + 16'd1;
        if (kind == K_NW_LIT) begin
          op_done = 1'b1;
          op_val  = mem_rdata;
        end else begin
          // Back-to-back read: request stays high with the new address.
          mem_addr_d = word_addr;
          state_d    = is_b ? B_READ : A_READ;
          if (!is_b) a_addr_d = word_addr;
        end
      end
      A_READ, B_READ: if (mem_ack) begin
        op_done = 1'b1;
        op_val  = mem_rdata;
      end
      OUT: if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (op_done) begin
      mem_req_d = 1'b0;
      state_d   = next_op_state;
      if (is_b) begin
        b_val_d = op_val;
      end else begin
        a_val_d    = op_val;
        rf_raddr_d = b_code_q[2:0];
      end
    end
  end

  assign valid_d = (state_d == OUT);
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      sp_q       <= '0;
      o_q        <= '0;
      opcode_q   <= '0;
      a_code_q   <= '0;
      b_code_q   <= '0;
      a_val_q    <= '0;
      b_val_q    <= '0;
      a_addr_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rf_raddr_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      o_q        <= o_d;
      opcode_q   <= opcode_d;
      a_code_q   <= a_code_d;
      b_code_q   <= b_code_d;
      a_val_q    <= a_val_d;
      b_val_q    <= b_val_d;
      a_addr_q   <= a_addr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rf_raddr_q <= rf_raddr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_raddr = rf_raddr_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign opcode   = opcode_q;
  assign a_code   = a_code_q;
  assign b_code   = b_code_q;
  assign a_val    = a_val_q;
  assign b_val    = b_val_q;
  assign a_addr   = a_addr_q;
  assign pc_out   = pc_q;
  assign sp_out   = sp_q;

endmodule

// File: tb/tb_dcpu_operand_fetch.sv
// Directed bench for dcpu_operand_fetch with a wait-state memory model and register file.
module tb_dcpu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [15:0] pc_in, sp_in, o_in;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, mem_rdata;
  logic        valid, busy;
  logic [3:0]  opcode;
  logic [5:0]  a_code, b_code;
  logic [15:0] a_val, b_val, a_addr, pc_out, sp_out;

  logic [15:0] mem [0:65535];
  logic [15:0] rf [0:7];
  int          wait_n = 0;
  int          ack_cnt = 0;
  int          total = 0;
  int          passed = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  assign rf_rdata  = rf[rf_raddr];
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (ack_cnt >= wait_n);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) ack_cnt <= ack_cnt + 1;
    else                     ack_cnt <= 0;
  end

  dcpu_operand_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .pc_in(pc_in), .sp_in(sp_in), .o_in(o_in),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid(valid), .ready(ready),
    .opcode(opcode), .a_code(a_code), .b_code(b_code),
    .a_val(a_val), .b_val(b_val), .a_addr(a_addr),
    .pc_out(pc_out), .sp_out(sp_out), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start_instr(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] o);
    pc_in = pc;
    sp_in = sp;
    o_in  = o;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (valid) break;
      step();
    end
    chk1(tag, valid, 1'b1);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    step();
    chk1({tag, "_valid_drop"}, valid, 1'b0);
    chk1({tag, "_idle"}, busy, 1'b0);
    ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    pc_in = 16'h0; sp_in = 16'h0; o_in = 16'h0;
    step();
    step();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_a_val", a_val, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    rst = 1'b0;
    step();

    // SET A, 31 with zero-wait memory: valid exactly four cycles after start.
    mem[16'h0100] = 16'hFC01;
    rf[0] = 16'h1111;
    start_instr(16'h0100, 16'hFFF0, 16'h0000);
    step();
    step();
    chk1("t1_not_yet_valid", valid, 1'b0);
    step();
    chk1("t1_valid_n4", valid, 1'b1);
    chk("t1_opcode", 16'(opcode), 16'h0001);
    chk("t1_a_code", 16'(a_code), 16'h0000);
    chk("t1_b_code", 16'(b_code), 16'h003F);
    chk("t1_a_val", a_val, 16'h1111);
    chk("t1_b_val", b_val, 16'h001F);
    chk("t1_pc_out", pc_out, 16'h0101);
    chk("t1_sp_out", sp_out, 16'hFFF0);
    accept("t1");

    // ADD [nw], nw with 3 wait states and ready held low for two cycles.
    mem[16'h0100] = 16'h7DE2;
    mem[16'h0101] = 16'h1000;
    mem[16'h0102] = 16'h1234;
    mem[16'h1000] = 16'h0005;
    wait_n = 3;
    start_instr(16'h0100, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk1("t2_fetch_req_stable", mem_req, 1'b1);
      chk("t2_fetch_addr_stable", mem_addr, 16'h0100);
      step();
    end
    wait_valid("t2_valid");
    for (int i = 0; i < 3; i++) begin
      chk1("t2_hold_valid", valid, 1'b1);
      chk("t2_a_addr", a_addr, 16'h1000);
      chk("t2_a_val", a_val, 16'h0005);
      chk("t2_b_val", b_val, 16'h1234);
      chk("t2_pc_out", pc_out, 16'h0103);
      if (i < 2) step();
    end
    accept("t2");

    // SET PUSH, A with SP=0: pre-decrement wraps to 0xFFFF.
    wait_n = 0;
    mem[16'h0100] = 16'h01A1;
    mem[16'hFFFF] = 16'hBEEF;
    start_instr(16'h0100, 16'h0000, 16'h0000);
    wait_valid("t3_valid");
    chk("t3_a_addr", a_addr, 16'hFFFF);
    chk("t3_sp_out", sp_out, 16'hFFFF);
    chk("t3_a_val", a_val, 16'hBEEF);
    chk("t3_b_val", b_val, 16'h1111);
    accept("t3");

    // Reset asserted while in A_WORD: immediate abandonment.
    mem[16'h0100] = 16'h7DE2;
    wait_n = 3;
    start_instr(16'h0100, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) step();
    chk1("t4_in_word_req", mem_req, 1'b1);
    chk("t4_in_word_addr", mem_addr, 16'h0101);
    chk("t4_in_word_raddr", 16'(rf_raddr), 16'h0006);
    rst = 1'b1;
    #1;
    chk1("t4_rst_mem_req", mem_req, 1'b0);
    chk1("t4_rst_valid", valid, 1'b0);
    chk1("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_pc_out", pc_out, 16'h0000);
    step();
    rst = 1'b0;
    wait_n = 0;
    step();
    start_instr(16'h0100, 16'h0000, 16'h0000);
    wait_valid("t4_after_valid");
    chk("t4_after_a_val", a_val, 16'h0005);
    chk("t4_after_b_val", b_val, 16'h1234);
    chk("t4_after_pc_out", pc_out, 16'h0103);
    accept("t4");

    // SET PC-value, nw at pc 0xFFFF: next word from 0x0000.
    mem[16'hFFFF] = 16'h7DC1;
    mem[16'h0000] = 16'hABCD;
    start_instr(16'hFFFF, 16'h0000, 16'h0000);
    step();
    step();
    step();
    chk1("t5_bword_req", mem_req, 1'b1);
    chk("t5_bword_addr", mem_addr, 16'h0000);
    wait_valid("t5_valid");
    chk("t5_a_val_pc", a_val, 16'h0000);
    chk("t5_b_val", b_val, 16'hABCD);
    chk("t5_pc_out", pc_out, 16'h0001);
    accept("t5");

    // Non-basic with POP: only a evaluated, b_val zero.
    mem[16'h0300] = 16'h6010;
    mem[16'h2000] = 16'h7777;
    start_instr(16'h0300, 16'h2000, 16'h0000);
    wait_valid("t6_valid");
    chk("t6_opcode", 16'(opcode), 16'h0000);
    chk("t6_a_code", 16'(a_code), 16'h0018);
    chk("t6_a_val", a_val, 16'h7777);
    chk("t6_a_addr", a_addr, 16'h2000);
    chk("t6_sp_out", sp_out, 16'h2001);
    chk("t6_b_val", b_val, 16'h0000);
    chk("t6_pc_out", pc_out, 16'h0301);
    accept("t6");

    // ADD [nw+B], O with a stray start while busy.
    mem[16'h0400] = 16'h7512;
    mem[16'h0401] = 16'h0010;
    mem[16'h2010] = 16'h4242;
    rf[1] = 16'h2000;
    wait_n = 1;
    start_instr(16'h0400, 16'h0000, 16'h5A5A);
    pc_in = 16'h0999;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t7_valid");
    chk("t7_a_addr", a_addr, 16'h2010);
    chk("t7_a_val", a_val, 16'h4242);
    chk("t7_b_val", b_val, 16'h5A5A);
    chk("t7_pc_out", pc_out, 16'h0402);
    accept("t7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dcpu_operand_fetch.md
DCPU_OPERAND_FETCH -- requirements
Module: dcpu_operand_fetch

Interface
REQ-001 Parameters: none; data and address width are fixed at 16 bits.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  begin fetch/decode of the instruction at pc_in; sampled only in IDLE.
REQ-006 pc_in, sp_in, o_in  in  16 each  architectural PC, SP, O; sampled on the start cycle.
REQ-007 rf_raddr  out  3  register-file read select; rf_rdata  in  16  combinational read data.
REQ-008 mem_req  out  1  read request; mem_addr  out  16  address; mem_ack  in  1  read done; mem_rdata  in  16  data, valid with mem_ack.
REQ-009 valid  out  1  decoded operands available; ready  in  1  consumer (ALU/writeback) accepts.
REQ-010 opcode  out  4; a_code, b_code  out  6 each  raw operand fields for writeback.
REQ-011 a_val, b_val  out  16  operand values; a_addr  out  16  effective address of a when a is memory.
REQ-012 pc_out, sp_out  out  16  updated PC and SP; busy  out  1  high whenever state is not IDLE.

Function
REQ-013 Instruction word: op=[3:0], a=[9:4], b=[15:10]; opcode 0 (non-basic): a=[15:10], only a is evaluated, b_val=0.
REQ-014 FSM states: IDLE, FETCH, A_EVAL, A_WORD, A_READ, B_EVAL, B_WORD, B_READ, OUT.
REQ-015 IDLE->FETCH on start; FETCH reads mem[PC], PC+=1, ->A_EVAL.
REQ-016 X_EVAL (one cycle) classifies code: 0x00-07 reg; 0x08-0f [reg]; 0x10-17 [word+reg]; 0x18 POP [SP++]; 0x19 PEEK [SP]; 0x1a PUSH [--SP]; 0x1b SP; 0x1c PC; 0x1d O; 0x1e [word]; 0x1f word; 0x20-3f literal code-0x20.
REQ-017 Direct values (reg, SP, PC, O, literal) captured in X_EVAL; then A->B_EVAL, B->OUT.
REQ-018 Word forms -> X_WORD: read mem[PC], PC+=1; literal word -> value; otherwise address = word (+rf_rdata for 0x10-17) -> X_READ.
REQ-019 Indirect forms -> X_READ: read mem[address]; value = mem_rdata; a_addr holds address for operand a.
REQ-020 rf_raddr = low 3 bits of the operand being evaluated in every A_*/B_* state.
REQ-021 Memory handshake: mem_req and mem_addr stable from state entry until the mem_ack cycle; ack may arrive in the same cycle as req; mem_req low the cycle after ack.
REQ-022 Latency: register/literal-only instruction with zero-wait memory: start at cycle N -> valid at N+4; each word/indirect access adds >=1 cycle.
REQ-023 OUT: valid high, all outputs stable until ready; valid&ready -> IDLE, valid low next cycle.
REQ-024 PC and SP arithmetic mod 2^16 (PC 0xFFFF+1=0x0000; PUSH at SP=0 -> 0xFFFF); a evaluated before b, SP effects cumulative.
REQ-025 start while busy is ignored; mem_ack outside a read state is ignored.

Reset
REQ-026 rst asserted: immediately state=IDLE, mem_req=0, valid=0, busy=0; all data outputs 0x0000.
REQ-027 Reset mid-access abandons the transaction; no PC/SP update is presented.

Structure
REQ-028 dcpu_defines holds opcode constants, operand-code constants (VAL_POP, VAL_PEEK, VAL_PUSH, VAL_SP, VAL_PC, VAL_O, VAL_NW_IND, VAL_NW_LIT) and FSM state encodings.
REQ-029 One sub-module: dcpu_operand_class, combinational 6-bit code -> operand kind, shared by A and B evaluation.

Verification
REQ-030 Word 0xFC01 (SET A,31), pc_in=0x0100, rf[0]=0x1111, zero-wait -> valid at N+4, opcode=1, a_val=0x1111, b_val=0x001F, pc_out=0x0101.
REQ-031 Word 0x7DE2 (ADD [nw],nw), mem[0x101]=0x1000, mem[0x102]=0x1234, mem[0x1000]=0x0005 -> a_addr=0x1000, a_val=0x0005, b_val=0x1234, pc_out=0x0103.
REQ-032 Word 0x01A1 (SET PUSH,A), sp_in=0x0000 -> a_addr=0xFFFF, sp_out=0xFFFF.
REQ-033 mem_ack delayed 3 cycles, ready low 2 cycles in OUT -> mem_addr/mem_req stable while waiting, outputs stable while valid&!ready.
REQ-034 rst pulsed during A_WORD -> mem_req and valid low immediately, busy=0; next start decodes correctly.
REQ-035 pc_in=0xFFFF, b=0x1f -> next word read from 0x0000, pc_out=0x0001.
